// File: rtl/accumulator_control_unit.sv
// -----------------------------------------------------------------------------
// accumulator_control_unit
//
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator
// machine. Owns the program counter, instruction register and memory buffer
// register. Drives the main-memory address/write strobe, the ALU opcode and
// the accumulator write strobe/source select.
//
// State sequence per instruction: F1 -> F2 -> DEC [-> MEM] [-> EX] -> F1.
// HALT (and a trapped undefined opcode) returns to IDLE.
//
// Optional feature macro: ACU_ILLEGAL_TRAP_EN
//   defined   : undefined opcodes (C..F) set a sticky 'illegal' flag and stop
//               in IDLE; 'run' cannot restart until reset.
//   undefined : undefined opcodes are 3-cycle NOPs and 'illegal' is tied 0.
//
// Ports:
//   clk         in   clock, all state updates on posedge
//   reset       in   synchronous active-high reset
//   run         in   level start/resume, sampled only in IDLE
//   mem_rdata   in   memory read data, valid the cycle after the address
//   acc_in      in   current accumulator value (JZ test, store data)
//   alu_result  in   ALU output (selected into the accumulator outside)
//   mem_addr    out  memory address, zero-extended 12-bit
//   mem_wdata   out  memory write data (= acc_in)
//   mem_we      out  memory write enable
//   alu_opcode  out  ALU operation select
//   acc_we      out  accumulator write strobe
//   acc_sel     out  accumulator source: 0 = alu_result, 1 = mbr
//   mbr         out  memory buffer register
//   pc          out  program counter, zero-extended
//   ir          out  instruction register
//   halted      out  high while in IDLE
//   illegal     out  sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module accumulator_control_unit #(
   parameter logic [11:0] START_PC = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] acc_in,
   input  logic [15:0] alu_result,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic [3:0]  alu_opcode,
   output logic        acc_we,
   output logic        acc_sel,
   output logic [15:0] mbr,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [2:0] {
      S_IDLE, S_F1, S_F2, S_DEC, S_MEM, S_EX
   } state_t;

   localparam logic [3:0] OP_HALT  = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_JMP   = 4'hA;
   localparam logic [3:0] OP_JZ    = 4'hB;

   state_t      state_q, state_d;
   logic [11:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] mbr_q, mbr_d;
   logic        run_ok;

   logic [3:0]  opcode;
   logic [11:0] addr_a;

   assign opcode = ir_q[15:12];
   assign addr_a = ir_q[11:0];

   // The ALU result is steered into the accumulator by the external mux;
   // this unit only selects between it and mbr.
   logic unused_alu;
   assign unused_alu = ^alu_result;

`ifdef ACU_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign run_ok  = run & ~illegal_q;
   assign illegal = illegal_q;
`else
   assign run_ok  = run;
   assign illegal = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      mbr_d   = mbr_q;
`ifdef ACU_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_IDLE: if (run_ok) state_d = S_F1;
         S_F1:   state_d = S_F2;
         S_F2: begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 12'd1;   // 12-bit wrap 0xFFF -> 0x000
            state_d = S_DEC;
         end
         S_DEC: begin
            case (opcode)
               OP_HALT:  state_d = S_IDLE;
               OP_STORE: state_d = S_F1;
               OP_JMP: begin
                  pc_d    = addr_a;
                  state_d = S_F1;
               end
               OP_JZ: begin
                  if (acc_in == 16'h0000) pc_d = addr_a;
                  state_d = S_F1;
               end
               OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                  state_d = S_MEM;
               OP_SHL, OP_SHR: state_d = S_EX;
               default: begin
`ifdef ACU_ILLEGAL_TRAP_EN
                  illegal_d = 1'b1;
                  state_d   = S_IDLE;
`else
                  state_d   = S_F1;
`endif
               end
            endcase
         end
         S_MEM: begin
            mbr_d   = mem_rdata;
            state_d = S_EX;
         end
         S_EX:    state_d = S_F1;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_PC;
         ir_q    <= 16'h0000;
         mbr_q   <= 16'h0000;
`ifdef ACU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mbr_q   <= mbr_d;
`ifdef ACU_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // ALU opcode decode; non-ALU instructions present 0000
   always_comb begin
      alu_opcode = 4'b0000;
      case (opcode)
         OP_SUB: alu_opcode = 4'b0001;
         OP_AND: alu_opcode = 4'b1000;
         OP_OR:  alu_opcode = 4'b1001;
         OP_XOR: alu_opcode = 4'b1010;
         OP_SHL: alu_opcode = 4'b0100;
         OP_SHR: alu_opcode = 4'b0101;
         default: alu_opcode = 4'b0000;
      endcase
   end

   assign mem_addr  = (state_q == S_DEC || state_q == S_MEM) ? {4'b0000, addr_a}
                                                             : {4'b0000, pc_q};
   assign mem_wdata = acc_in;
   // Strobes are masked by reset so a write in flight cannot land on the
   // reset edge.
   assign mem_we    = ~reset & (state_q == S_DEC) & (opcode == OP_STORE);
   assign acc_we    = ~reset & (state_q == S_EX);
   assign acc_sel   = (state_q == S_EX) & (opcode == OP_LOAD);
   assign mbr       = mbr_q;
   assign pc        = {4'b0000, pc_q};
   assign ir        = ir_q;
   assign halted    = (state_q == S_IDLE);

endmodule

// File: tb/tb_accumulator_control_unit.sv
module tb_accumulator_control_unit;

   logic        clk;
   logic        reset;
   logic        run;
   logic [15:0] mem_rdata;
   logic [15:0] acc;
   logic [15:0] alu_res;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [3:0]  alu_opcode;
   logic        acc_we;
   logic        acc_sel;
   logic [15:0] mbr;
   logic [15:0] pc;
   logic [15:0] ir;
   logic        halted;
   logic        illegal;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   logic [15:0] r_acc;
   logic [11:0] r_pc;
   bit          r_ill;

   accumulator_control_unit #(.START_PC(12'h000)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata),
      .acc_in(acc), .alu_result(alu_res), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .alu_opcode(alu_opcode),
      .acc_we(acc_we), .acc_sel(acc_sel), .mbr(mbr), .pc(pc), .ir(ir),
      .halted(halted), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: synchronous memory, ALU and accumulator register
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr[11:0]];
      if (mem_we) mem[mem_addr[11:0]] = mem_wdata;
   end

   always_comb begin
      alu_res = acc;
      case (alu_opcode)
         4'b0000: alu_res = acc + mbr;
         4'b0001: alu_res = acc - mbr;
         4'b1000: alu_res = acc & mbr;
         4'b1001: alu_res = acc | mbr;
         4'b1010: alu_res = acc ^ mbr;
         4'b0100: alu_res = acc << 1;
         4'b0101: alu_res = acc >> 1;
         default: alu_res = acc;
      endcase
   end

   always @(posedge clk) begin
      if (reset)       acc <= 16'h0000;
      else if (acc_we) acc <= acc_sel ? mbr : alu_res;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   // Start from IDLE; returns cycles from the first F1 until halted rises,
   // and the address driven in that first F1.
   task automatic run_prog(input bit hold, output int cyc, output logic [15:0] first_addr);
      @(posedge clk);
      #1 run = 1'b1;
      step(1);
      first_addr = mem_addr;
      if (!hold) run = 1'b0;
      cyc = 0;
      while (!halted && cyc < 3000) begin
         step(1);
         cyc++;
      end
      run = 1'b0;
      if (cyc >= 3000) check_eq("run_timeout", 32'd1, 32'd0);
   endtask

   // Instruction-level reference: executes the program in ref_mem.
   task automatic ref_run(output int cyc);
      logic [15:0] w;
      logic [3:0]  op;
      logic [11:0] a;
      bit          done;
      cyc = 0;
      done = 0;
      r_ill = 0;
      for (int k = 0; k < 500 && !done; k++) begin
         w = ref_mem[r_pc];
         r_pc = r_pc + 12'd1;
         op = w[15:12];
         a = w[11:0];
         case (op)
            4'h0: begin cyc += 3; done = 1; end
            4'h1: begin r_acc = ref_mem[a]; cyc += 5; end
            4'h2: begin ref_mem[a] = r_acc; cyc += 3; end
            4'h3: begin r_acc = r_acc + ref_mem[a]; cyc += 5; end
            4'h4: begin r_acc = r_acc - ref_mem[a]; cyc += 5; end
            4'h5: begin r_acc = r_acc & ref_mem[a]; cyc += 5; end
            4'h6: begin r_acc = r_acc | ref_mem[a]; cyc += 5; end
            4'h7: begin r_acc = r_acc ^ ref_mem[a]; cyc += 5; end
            4'h8: begin r_acc = {r_acc[14:0], 1'b0}; cyc += 4; end
            4'h9: begin r_acc = {1'b0, r_acc[15:1]}; cyc += 4; end
            4'hA: begin r_pc = a; cyc += 3; end
            4'hB: begin if (r_acc == 16'h0000) r_pc = a; cyc += 3; end
            default: begin
               cyc += 3;
`ifdef ACU_ILLEGAL_TRAP_EN
               r_ill = 1;
               done = 1;
`endif
            end
         endcase
      end
   endtask

   initial begin
      int          cyc, rcyc;
      logic [15:0] fa;
      logic [3:0]  op;
      reset = 1'b1;
      run   = 1'b0;
      clear_mem();
      step(2);
      reset = 1'b0;

      // Reset state
      check_eq("rst_halted", halted, 1);
      check_eq("rst_pc", pc, 16'h0000);
      check_eq("rst_ir", ir, 16'h0000);
      check_eq("rst_mbr", mbr, 16'h0000);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_acc_we", acc_we, 0);
      check_eq("rst_acc_sel", acc_sel, 0);
      check_eq("rst_alu_op", alu_opcode, 4'b0000);
      check_eq("rst_illegal", illegal, 0);
      check_eq("rst_mem_addr", mem_addr, 16'h0000);

      // Sample program: 5 + 7 stored at 0x012
      mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h0000;
      mem[16'h010] = 16'd5; mem[16'h011] = 16'd7;
      run_prog(0, cyc, fa);
      check_eq("prog_first_addr", fa, 16'h0000);
      check_eq("prog_result", mem[12'h012], 16'd12);
      check_eq("prog_cycles", cyc, 16);
      check_eq("prog_pc", pc, 16'h0004);
      check_eq("prog_acc", acc, 16'd12);

      // Same program with run held high throughout
      mem[12'h012] = 16'h0000;
      do_reset();
      run_prog(1, cyc, fa);
      check_eq("hold_result", mem[12'h012], 16'd12);
      check_eq("hold_cycles", cyc, 16);
      check_eq("hold_pc", pc, 16'h0004);
      // Resume after HALT: fetch from 0x004 (a HALT word)
      run_prog(0, cyc, fa);
      check_eq("resume_addr", fa, 16'h0004);
      check_eq("resume_cycles", cyc, 3);
      check_eq("resume_pc", pc, 16'h0005);

      // JZ taken (ACC = 0)
      clear_mem();
      mem[0] = 16'h1013; mem[1] = 16'hB020; mem[2] = 16'h0000; mem[12'h020] = 16'h0000;
      mem[12'h013] = 16'h0000;
      do_reset();
      run_prog(0, cyc, fa);
      check_eq("jz_taken_pc", pc, 16'h0021);
      check_eq("jz_taken_cycles", cyc, 11);
      // JZ not taken (ACC = 3)
      mem[12'h013] = 16'h0003;
      do_reset();
      run_prog(0, cyc, fa);
      check_eq("jz_nt_pc", pc, 16'h0003);
      check_eq("jz_nt_acc", acc, 16'h0003);

      // SHL
      clear_mem();
      mem[0] = 16'h1014; mem[1] = 16'h8000; mem[2] = 16'h0000; mem[12'h014] = 16'h8001;
      do_reset();
      run_prog(0, cyc, fa);
      check_eq("shl_acc", acc, 16'h0002);
      check_eq("shl_cycles", cyc, 12);

      // PC wrap-around: JMP 0xFFF, LOAD at 0xFFF, next fetch at 0x000
      clear_mem();
      mem[0] = 16'hAFFF; mem[12'hFFF] = 16'h1010; mem[12'h010] = 16'h1234;
      do_reset();
      @(posedge clk);
      #1 run = 1'b1;
      step(1);
      run = 1'b0;
      step(3);
      check_eq("wrap_fetch_fff", mem_addr, 16'h0FFF);
      step(5);
      check_eq("wrap_fetch_000", mem_addr, 16'h0000);
      check_eq("wrap_acc", acc, 16'h1234);
      check_eq("wrap_halted", halted, 0);
      do_reset();

      // Reset during DEC of STORE
      clear_mem();
      mem[0] = 16'h1010; mem[1] = 16'h2012; mem[2] = 16'h0000;
      mem[12'h010] = 16'h5555; mem[12'h012] = 16'hAAAA;
      do_reset();
      @(posedge clk);
      #1 run = 1'b1;
      step(1);
      run = 1'b0;
      step(7);
      check_eq("rstdec_we_before", mem_we, 1);
      reset = 1'b1;
      step(1);
      check_eq("rstdec_we_after", mem_we, 0);
      check_eq("rstdec_halted", halted, 1);
      check_eq("rstdec_pc", pc, 16'h0000);
      reset = 1'b0;
      step(1);
      check_eq("rstdec_mem", mem[12'h012], 16'hAAAA);

      // Undefined opcode
      clear_mem();
      mem[0] = 16'hC000; mem[1] = 16'h0000;
      do_reset();
      run_prog(0, cyc, fa);
`ifdef ACU_ILLEGAL_TRAP_EN
      check_eq("trap_cycles", cyc, 3);
      check_eq("trap_illegal", illegal, 1);
      check_eq("trap_pc", pc, 16'h0001);
      @(posedge clk);
      #1 run = 1'b1;
      step(3);
      run = 1'b0;
      check_eq("trap_run_ignored", halted, 1);
      check_eq("trap_pc_hold", pc, 16'h0001);
`else
      check_eq("nop_cycles", cyc, 6);
      check_eq("nop_illegal", illegal, 0);
      check_eq("nop_pc", pc, 16'h0002);
`endif

      // Randomized programs against the instruction-level reference
      for (int t = 0; t < 12; t++) begin
         clear_mem();
         for (int d = 0; d < 16; d++) mem[12'h100 + d] = 16'($urandom);
         mem[0] = {4'h1, 12'h100 + 12'($urandom_range(0, 15))};
         for (int i = 1; i < 12; i++) begin
            op = 4'($urandom_range(1, 15));
            if (op == 4'hA || op == 4'hB)
               mem[i] = {op, 12'(i + 1 + $urandom_range(0, 2))};
            else if (op <= 4'h7)
               mem[i] = {op, 12'h100 + 12'($urandom_range(0, 15))};
            else
               mem[i] = {op, 12'($urandom)};
         end
         for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
         r_acc = 16'h0000;
         r_pc  = 12'h000;
         ref_run(rcyc);
         do_reset();
         run_prog(0, cyc, fa);
         check_eq("rnd_cycles", cyc, rcyc);
         check_eq("rnd_acc", acc, r_acc);
         check_eq("rnd_pc", pc, {4'h0, r_pc});
         check_eq("rnd_illegal", illegal, r_ill);
         for (int d = 0; d < 16; d++)
            check_eq("rnd_mem", mem[12'h100 + d], ref_mem[12'h100 + d]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
